// File: rtl/dual_port_sram_pkg.sv
// Shared types and helpers for the dual-port SRAM block: FSM state encoding,
// lane arithmetic and per-lane even-parity.
package dual_port_sram_pkg;

    localparam int LANE_W_DEF = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sram_state_e;

    function automatic int lane_count(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    // Callers zero-extend a lane into the 64-bit argument; padding does not change the XOR.
    function automatic logic lane_parity(input logic [63:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/dual_port_sram_init_seq.sv
// Clear sequencer: walks every word once after reset or init_req, then hands the
// array over to normal traffic.
module dual_port_sram_init_seq
    import dual_port_sram_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_DEPTH      = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init_req,
    output logic                      init_busy,
    output logic                      init_done,
    output logic [RAM_ADDR_WIDTH-1:0] clr_ptr
);

    sram_state_e               state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        init_done = 1'b0;
        case (state_q)
            CLEAR: begin
                if (init_req) begin
                    ptr_d = '0;
                end else if (ptr_q == RAM_ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                    init_done = 1'b1;
                    state_d   = RUN;
                    ptr_d     = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            RUN: begin
                if (init_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign init_busy = (state_q == CLEAR);
    assign clr_ptr   = ptr_q;

endmodule

// File: rtl/dual_port_sram_ext.sv
// Simple dual-port SRAM (port 0 read, port 1 write) with lane mask, sequenced clear,
// write-first forwarding and 1/2-cycle read pipe. Optional DUAL_PORT_SRAM_PARITY_EN.
module dual_port_sram_ext
    import dual_port_sram_pkg::*;
#(
    parameter int RAM_DATA_WIDTH = 272,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_DEPTH      = 256,
    parameter int LANE_W         = LANE_W_DEF,
    parameter int RD_LATENCY     = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               init_req,
    output logic                               init_busy,
    output logic                               init_done,
    input  logic                               port_en_0,
    input  logic                               rd_en,
    input  logic [RAM_ADDR_WIDTH-1:0]          addr_in_0,
    output logic [RAM_DATA_WIDTH-1:0]          data_out_0,
    output logic                               rd_valid_0,
    output logic                               rd_err_0,
    input  logic                               port_en_1,
    input  logic                               wr_en,
    input  logic [RAM_ADDR_WIDTH-1:0]          addr_in_1,
    input  logic [RAM_DATA_WIDTH-1:0]          data_in,
    input  logic [RAM_DATA_WIDTH/LANE_W-1:0]   wr_mask,
    output logic                               wr_ready_1
);

    localparam int NLANE = lane_count(RAM_DATA_WIDTH, LANE_W);

    if (RAM_DATA_WIDTH % LANE_W != 0) begin : g_bad_lane
        $error("RAM_DATA_WIDTH must be a multiple of LANE_W");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
        $error("RD_LATENCY must be 1 or 2");
    end
    if (RAM_DEPTH > (1 << RAM_ADDR_WIDTH)) begin : g_bad_depth
        $error("RAM_DEPTH exceeds address space");
    end

    logic [RAM_ADDR_WIDTH-1:0] clr_ptr;

    dual_port_sram_init_seq #(
        .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH),
        .RAM_DEPTH      (RAM_DEPTH)
    ) u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_req  (init_req),
        .init_busy (init_busy),
        .init_done (init_done),
        .clr_ptr   (clr_ptr)
    );

    assign wr_ready_1 = !init_busy;

    logic [RAM_DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic                      wr_in_range, rd_in_range;
    logic                      wr_acc, rd_acc, collide;
    logic                      mem_we;
    logic [RAM_ADDR_WIDTH-1:0] mem_waddr;
    logic [RAM_DATA_WIDTH-1:0] wr_old, wr_merged, mem_wdata, rd_word;
    logic                      par_err;

    // Address compare is one bit wider so RAM_DEPTH == 2**RAM_ADDR_WIDTH is representable.
    assign wr_in_range = {1'b0, addr_in_1} < (RAM_ADDR_WIDTH + 1)'(RAM_DEPTH);
    assign rd_in_range = {1'b0, addr_in_0} < (RAM_ADDR_WIDTH + 1)'(RAM_DEPTH);
    assign wr_acc      = port_en_1 & wr_en & wr_ready_1 & wr_in_range & (|wr_mask);
    assign rd_acc      = port_en_0 & rd_en & !init_busy;
    assign collide     = wr_acc & (addr_in_0 == addr_in_1);

    always_comb begin
        wr_old = mem_q[addr_in_1];
        for (int i = 0; i < NLANE; i++) begin
            wr_merged[i*LANE_W +: LANE_W] = wr_mask[i] ? data_in[i*LANE_W +: LANE_W]
                                                       : wr_old[i*LANE_W +: LANE_W];
        end
    end

    assign mem_we    = rst_n & (init_busy | wr_acc);
    assign mem_waddr = init_busy ? clr_ptr : addr_in_1;
    assign mem_wdata = init_busy ? '0 : wr_merged;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = collide ? wr_merged : mem_q[addr_in_0];
        end
    end

`ifdef DUAL_PORT_SRAM_PARITY_EN
    logic [NLANE-1:0] par_q [RAM_DEPTH];
    logic [NLANE-1:0] par_old, par_merged, par_wdata, rd_par;

    always_comb begin
        par_old = par_q[addr_in_1];
        for (int i = 0; i < NLANE; i++) begin
            par_merged[i] = wr_mask[i] ? lane_parity(64'(data_in[i*LANE_W +: LANE_W]))
                                       : par_old[i];
        end
        par_wdata = init_busy ? '0 : par_merged;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            par_q[mem_waddr] <= par_wdata;
        end
    end

    always_comb begin
        rd_par  = collide ? par_merged : par_q[addr_in_0];
        par_err = 1'b0;
        for (int i = 0; i < NLANE; i++) begin
            if (lane_parity(64'(rd_word[i*LANE_W +: LANE_W])) != rd_par[i]) begin
                par_err = 1'b1;
            end
        end
        par_err = par_err & rd_in_range;
    end
`else
    assign par_err = 1'b0;
`endif

    // Read pipe stage 1: capture accepted read
    logic                      vld_p1_q, vld_p1_d;
    logic                      err_p1_q, err_p1_d;
    logic [RAM_DATA_WIDTH-1:0] data_p1_q, data_p1_d;

    always_comb begin
        vld_p1_d  = rd_acc;
        err_p1_d  = rd_acc & (!rd_in_range | par_err);
        data_p1_d = rd_acc ? rd_word : data_p1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            err_p1_q  <= 1'b0;
            data_p1_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            err_p1_q  <= err_p1_d;
            data_p1_q <= data_p1_d;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        // Read pipe stage 2: optional output register
        logic                      vld_p2_q, vld_p2_d;
        logic                      err_p2_q, err_p2_d;
        logic [RAM_DATA_WIDTH-1:0] data_p2_q, data_p2_d;

        always_comb begin
            vld_p2_d  = vld_p1_q;
            err_p2_d  = err_p1_q;
            data_p2_d = vld_p1_q ? data_p1_q : data_p2_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_p2_q  <= 1'b0;
                err_p2_q  <= 1'b0;
                data_p2_q <= '0;
            end else begin
                vld_p2_q  <= vld_p2_d;
                err_p2_q  <= err_p2_d;
                data_p2_q <= data_p2_d;
            end
        end

        assign rd_valid_0 = vld_p2_q;
        assign rd_err_0   = err_p2_q;
        assign data_out_0 = data_p2_q;
    end else begin : g_lat1
        assign rd_valid_0 = vld_p1_q;
        assign rd_err_0   = err_p1_q;
        assign data_out_0 = data_p1_q;
    end

endmodule

// File: tb/tb_dual_port_sram_ext.sv
// Directed bench for dual_port_sram_ext: clear sequence, masked writes, write-first
// collisions, out-of-range access (RAM_DEPTH=200 instance) and re-init.
module tb_dual_port_sram_ext;

    localparam int DW = 272;
    localparam int AW = 8;
    localparam int NL = 34;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance (RAM_DEPTH=256)
    logic          init_req, pe0, rd_en, pe1, wr_en;
    logic [AW-1:0] raddr, waddr;
    logic [DW-1:0] wdata;
    logic [NL-1:0] wmask;
    logic          busy, done, rvld, rerr, wrdy;
    logic [DW-1:0] dout;

    // Short instance (RAM_DEPTH=200)
    logic          b_init_req, b_pe0, b_rd_en, b_pe1, b_wr_en;
    logic [AW-1:0] b_raddr, b_waddr;
    logic [DW-1:0] b_wdata;
    logic [NL-1:0] b_wmask;
    logic          b_busy, b_done, b_rvld, b_rerr, b_wrdy;
    logic [DW-1:0] b_dout;

    dual_port_sram_ext dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_busy(busy), .init_done(done),
        .port_en_0(pe0), .rd_en(rd_en), .addr_in_0(raddr), .data_out_0(dout),
        .rd_valid_0(rvld), .rd_err_0(rerr), .port_en_1(pe1), .wr_en(wr_en),
        .addr_in_1(waddr), .data_in(wdata), .wr_mask(wmask), .wr_ready_1(wrdy)
    );

    dual_port_sram_ext #(.RAM_DEPTH(200)) dut_b (
        .clk(clk), .rst_n(rst_n), .init_req(b_init_req), .init_busy(b_busy), .init_done(b_done),
        .port_en_0(b_pe0), .rd_en(b_rd_en), .addr_in_0(b_raddr), .data_out_0(b_dout),
        .rd_valid_0(b_rvld), .rd_err_0(b_rerr), .port_en_1(b_pe1), .wr_en(b_wr_en),
        .addr_in_1(b_waddr), .data_in(b_wdata), .wr_mask(b_wmask), .wr_ready_1(b_wrdy)
    );

    typedef struct {
        logic          pe0;
        logic          rd;
        logic [AW-1:0] raddr;
        logic          pe1;
        logic          wr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [NL-1:0] wmask;
        logic          exp_vld;
        logic          exp_err;
        logic [DW-1:0] exp_data;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        logic [DW-1:0] w;
        for (int i = 0; i < NL; i++) w[i*8 +: 8] = b;
        return w;
    endfunction

    function automatic logic [DW-1:0] set_lane(input logic [DW-1:0] w, input int i,
                                               input logic [7:0] b);
        logic [DW-1:0] r;
        r = w;
        r[i*8 +: 8] = b;
        return r;
    endfunction

    function automatic vec_t mk(input logic p0, input logic r, input logic [AW-1:0] ra,
                                input logic p1, input logic w, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd, input logic [NL-1:0] wm,
                                input logic ev, input logic ee, input logic [DW-1:0] ed);
        vec_t v;
        v.pe0 = p0; v.rd = r; v.raddr = ra; v.pe1 = p1; v.wr = w; v.waddr = wa;
        v.wdata = wd; v.wmask = wm; v.exp_vld = ev; v.exp_err = ee; v.exp_data = ed;
        return v;
    endfunction

    task automatic idle();
        init_req = 1'b0; pe0 = 1'b1; rd_en = 1'b0; pe1 = 1'b1; wr_en = 1'b0;
    endtask

    task automatic read1(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        rd_en = 1'b1; raddr = a;
        step();
        rd_en = 1'b0;
        chk({name, "_vld"}, DW'(rvld), DW'(1));
        chk({name, "_err"}, DW'(rerr), DW'(0));
        chk({name, "_data"}, dout, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vt [12];
        logic [DW-1:0] w_a5, w10a, w10b, w11;
        logic [NL-1:0] m_all, m_l0, m_l33;
        int            busy_bad, done_at, done_cnt, cnt, vbad;

        w_a5  = rep(8'hA5);
        w10a  = set_lane(w_a5, 0, 8'h3C);
        w10b  = set_lane(w10a, 33, 8'h77);
        w11   = rep(8'h11);
        m_all = '1;
        m_l0  = '0; m_l0[0] = 1'b1;
        m_l33 = '0; m_l33[33] = 1'b1;

        vt[0]  = mk(1, 1, 8'h00, 1, 0, 8'h00, '0,          '0,    1, 0, '0);
        vt[1]  = mk(1, 1, 8'hFF, 1, 0, 8'h00, '0,          '0,    1, 0, '0);
        vt[2]  = mk(1, 0, 8'h00, 1, 1, 8'h10, w_a5,        m_all, 0, 0, '0);
        vt[3]  = mk(1, 0, 8'h00, 1, 1, 8'h10, rep(8'h3C),  m_l0,  0, 0, '0);
        vt[4]  = mk(1, 1, 8'h10, 1, 0, 8'h00, '0,          '0,    1, 0, w10a);
        vt[5]  = mk(1, 1, 8'h20, 1, 1, 8'h20, w11,         m_all, 1, 0, w11);
        vt[6]  = mk(1, 1, 8'h10, 1, 1, 8'h10, rep(8'h77),  m_l33, 1, 0, w10b);
        vt[7]  = mk(1, 1, 8'h20, 1, 1, 8'h20, rep(8'hFF),  '0,    1, 0, w11);
        vt[8]  = mk(1, 0, 8'h00, 0, 1, 8'h30, rep(8'h55),  m_all, 0, 0, w11);
        vt[9]  = mk(1, 1, 8'h30, 1, 0, 8'h00, '0,          '0,    1, 0, '0);
        vt[10] = mk(0, 1, 8'h10, 1, 0, 8'h00, '0,          '0,    0, 0, '0);
        vt[11] = mk(1, 1, 8'h10, 1, 0, 8'h00, '0,          '0,    1, 0, w10b);

        rst_n = 1'b0;
        idle();
        raddr = '0; waddr = '0; wdata = '0; wmask = '0;
        b_init_req = 1'b0; b_pe0 = 1'b1; b_rd_en = 1'b0; b_pe1 = 1'b1; b_wr_en = 1'b0;
        b_raddr = '0; b_waddr = '0; b_wdata = '0; b_wmask = '0;
        repeat (3) step();

        chk("reset_busy", DW'(busy), DW'(1));
        chk("reset_done", DW'(done), DW'(0));
        chk("reset_vld", DW'(rvld), DW'(0));
        chk("reset_err", DW'(rerr), DW'(0));
        chk("reset_data", dout, '0);
        chk("reset_wr_ready", DW'(wrdy), DW'(0));

        rst_n = 1'b1;
        busy_bad = 0; done_at = -1; done_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (!busy) busy_bad++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i + 1;
            end
            step();
        end
        chk("init_busy_window", DW'(busy_bad), DW'(0));
        chk("init_done_cycle", DW'(done_at), DW'(256));
        chk("init_done_pulses", DW'(done_cnt), DW'(1));
        chk("init_busy_after", DW'(busy), DW'(0));
        chk("init_wr_ready_after", DW'(wrdy), DW'(1));

        for (int k = 0; k < 12; k++) begin
            pe0 = vt[k].pe0; rd_en = vt[k].rd; raddr = vt[k].raddr;
            pe1 = vt[k].pe1; wr_en = vt[k].wr; waddr = vt[k].waddr;
            wdata = vt[k].wdata; wmask = vt[k].wmask;
            step();
            idle();
            chk($sformatf("vec%0d_vld", k), DW'(rvld), DW'(vt[k].exp_vld));
            if (vt[k].exp_vld) chk($sformatf("vec%0d_err", k), DW'(rerr), DW'(vt[k].exp_err));
            chk($sformatf("vec%0d_data", k), dout, vt[k].exp_data);
        end

        // Back-to-back reads, one per cycle
        rd_en = 1'b1; raddr = 8'h10;
        step();
        chk("b2b_first_vld", DW'(rvld), DW'(1));
        chk("b2b_first_data", dout, w10b);
        raddr = 8'h20;
        step();
        rd_en = 1'b0;
        chk("b2b_second_vld", DW'(rvld), DW'(1));
        chk("b2b_second_data", dout, w11);
        step();
        chk("b2b_idle_vld", DW'(rvld), DW'(0));
        chk("b2b_hold_data", dout, w11);

        // Out-of-range on the 200-word instance
        chk("short_init_idle", DW'(b_busy), DW'(0));
        b_wr_en = 1'b1; b_waddr = 8'hC8; b_wdata = rep(8'hEE); b_wmask = m_all;
        step();
        b_waddr = 8'hC7; b_wdata = rep(8'h42);
        step();
        b_wr_en = 1'b0;
        b_rd_en = 1'b1; b_raddr = 8'hC8;
        step();
        chk("oor_vld", DW'(b_rvld), DW'(1));
        chk("oor_err", DW'(b_rerr), DW'(1));
        chk("oor_data", b_dout, '0);
        b_raddr = 8'hC7;
        step();
        b_rd_en = 1'b0;
        chk("last_word_vld", DW'(b_rvld), DW'(1));
        chk("last_word_err", DW'(b_rerr), DW'(0));
        chk("last_word_data", b_dout, rep(8'h42));

        // Re-init: read issued alongside init_req completes; traffic blocked during clear
        wr_en = 1'b1; waddr = 8'h40; wdata = rep(8'h99); wmask = m_all;
        step();
        wr_en = 1'b0;
        init_req = 1'b1; rd_en = 1'b1; raddr = 8'h10;
        step();
        init_req = 1'b0;
        wr_en = 1'b1; waddr = 8'h40; wdata = rep(8'hFF); wmask = m_all;
        chk("reinit_inflight_vld", DW'(rvld), DW'(1));
        chk("reinit_inflight_data", dout, w10b);
        chk("reinit_wr_ready", DW'(wrdy), DW'(0));
        cnt = 0; vbad = 0;
        while (busy && cnt < 300) begin
            if (cnt > 0 && rvld) vbad++;
            cnt++;
            step();
        end
        idle();
        chk("reinit_clear_cycles", DW'(cnt), DW'(256));
        chk("reinit_no_rd_valid", DW'(vbad), DW'(0));
        read1(8'h10, '0, "reinit_rd10");
        read1(8'h20, '0, "reinit_rd20");
        read1(8'h40, '0, "reinit_rd40");

`ifdef DUAL_PORT_SRAM_PARITY_EN
        wr_en = 1'b1; waddr = 8'h05; wdata = rep(8'h5A); wmask = m_all;
        step();
        waddr = 8'h06;
        step();
        wr_en = 1'b0;
        dut.mem_q[5][3] = ~dut.mem_q[5][3];
        rd_en = 1'b1; raddr = 8'h05;
        step();
        chk("parity_bad_vld", DW'(rvld), DW'(1));
        chk("parity_bad_err", DW'(rerr), DW'(1));
        raddr = 8'h06;
        step();
        rd_en = 1'b0;
        chk("parity_clean_err", DW'(rerr), DW'(0));
        chk("parity_clean_data", dout, rep(8'h5A));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
